// File: rtl/soc_trace_pkg.sv
// Shared constants for the SoC debug-trace UART: frame layout,
// record width and serializer state codes.
package soc_trace_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 13;
    localparam int         REC_W       = 96;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Byte idx of a frame: 0 is the sync byte, then the record MSB first.
    function automatic logic [7:0] frame_byte(
        input logic [REC_W-1:0] rec,
        input logic [3:0]       idx
    );
        logic [REC_W-1:0] sh;
        sh = rec >> (8 * (FRAME_BYTES - 1 - int'(idx)));
        return (idx == 4'd0) ? SYNC_BYTE : sh[7:0];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with registered level, full and empty.
// Reset empties it; writes when full and reads when empty are ignored.
module trace_fifo
    import soc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [REC_W-1:0] din,
    input  logic             pop,
    output logic [REC_W-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
                full  <= (level == LVL_W'(DEPTH - 1));
                empty <= 1'b0;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
                full  <= 1'b0;
                empty <= (level == LVL_W'(1));
            end
        end
    end

endmodule

// File: rtl/soc_trace_uart.sv
// Captures changes of the SoC debug triple into a FIFO and streams
// each record as a 13-byte 8N1 UART frame; never stalls the SoC.
module soc_trace_uart
    import soc_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int LVL_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ram_addr,
    input  logic [31:0]      ram_data,
    input  logic [31:0]      cp0_exc_addr,
    input  logic             enable,
    output logic             uart_tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic [15:0]      drop_count
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [REC_W-1:0] triple;
    logic [REC_W-1:0] last;
    logic             first;
    logic             capture;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_dout;
    logic             pop;
    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [REC_W-1:0] rec;
    logic [7:0]       shreg;

    assign triple  = {ram_addr, ram_data, cp0_exc_addr};
    assign capture = enable && (first || (triple != last));
    assign tc      = (cnt == CW'(CLKS_PER_BIT - 1));
    assign busy    = (state != S_IDLE) || !fifo_empty;

    assign pop = !fifo_empty &&
                 ((state == S_IDLE) ||
                  ((state == S_STOP) && tc &&
                   (byte_idx == 4'(FRAME_BYTES - 1))));

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .din   (triple),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // last/first advance even when the push is dropped: no retry.
    always_ff @(posedge clk) begin
        if (reset) begin
            last       <= '0;
            first      <= 1'b1;
            drop_count <= '0;
        end else if (capture) begin
            last  <= triple;
            first <= 1'b0;
            if (fifo_full && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || state == S_LOAD || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The record is taken at pop time since the FIFO head moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            uart_tx  <= 1'b1;
            bit_idx  <= '0;
            byte_idx <= '0;
            rec      <= '0;
            shreg    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        rec   <= fifo_dout;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    uart_tx  <= 1'b0;
                    byte_idx <= '0;
                    shreg    <= SYNC_BYTE;
                    state    <= S_START;
                end
                S_START: begin
                    if (tc) begin
                        uart_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tc) begin
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                S_STOP: begin
                    if (tc) begin
                        if (byte_idx != 4'(FRAME_BYTES - 1)) begin
                            byte_idx <= byte_idx + 4'd1;
                            shreg    <= frame_byte(rec, byte_idx + 4'd1);
                            uart_tx  <= 1'b0;
                            state    <= S_START;
                        end else if (!fifo_empty) begin
                            rec   <= fifo_dout;
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_trace_uart.sv
// Randomised scoreboard bench for soc_trace_uart with a UART decoder
// monitor and a cycle-level reference model of capture and drain.
module tb_soc_trace_uart;

    localparam int CPB       = 4;
    localparam int DEPTH     = 16;
    localparam int LW        = 5;
    localparam int FRAME_CYC = 130 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [31:0]   ra = 32'h10;
    logic [31:0]   rd = 32'hDEADBEEF;
    logic [31:0]   ce = 32'h0;
    logic          uart_tx;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_count;

    soc_trace_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .LVL_W        (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ram_addr     (ra),
        .ram_data     (rd),
        .cp0_exc_addr (ce),
        .enable       (enable),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int t = 0;

    bit [95:0] m_q[$];
    bit [95:0] exp_q[$];
    bit [95:0] m_last = '0;
    bit        m_first = 1'b1;
    int        m_drop = 0;
    int        last_pop = 0;
    bit        popped = 1'b0;
    bit        rst_prev = 1'b0;
    bit        cur_en = 1'b1;
    bit [95:0] cur = {32'h10, 32'hDEADBEEF, 32'h0};

    function automatic void cmp(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
        end
    endfunction

    function automatic bit m_busy();
        return (m_q.size() > 0) ||
               (popped && t <= last_pop + 1 + FRAME_CYC);
    endfunction

    // One cycle: check registered outputs, drive inputs, advance model.
    task automatic step(input bit rst, input bit en, input bit [95:0] trip);
        bit full;
        bit cap;
        @(posedge clk);
        #1;
        if (rst_prev) exp_q.delete();
        cmp("level", fifo_level, m_q.size());
        cmp("drop", drop_count, m_drop);
        cmp("busy", busy, m_busy());
        if (popped && t == last_pop + 1) cmp("load_tx", uart_tx, 1);
        if (popped && t == last_pop + 2) cmp("start_tx", uart_tx, 0);
        if (!m_busy()) cmp("idle_tx", uart_tx, 1);
        reset  = rst;
        enable = en;
        {ra, rd, ce} = trip;
        if (rst) begin
            m_q.delete();
            m_drop  = 0;
            m_last  = '0;
            m_first = 1'b1;
            popped  = 1'b0;
        end else begin
            full = (m_q.size() >= DEPTH);
            cap  = en && (m_first || trip != m_last);
            if (m_q.size() > 0 &&
                (!popped || t >= last_pop + 1 + FRAME_CYC)) begin
                void'(m_q.pop_front());
                last_pop = t;
                popped   = 1'b1;
            end
            if (cap) begin
                m_last  = trip;
                m_first = 1'b0;
                if (!full) begin
                    m_q.push_back(trip);
                    exp_q.push_back(trip);
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end
        end
        rst_prev = rst;
        t++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(0, cur_en, cur);
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy() && n < 20000) begin
            step(0, cur_en, cur);
            n++;
        end
        hold(8);
        cmp("drain_busy", busy, 0);
    endtask

    // UART decoder: samples mid-bit on the falling clock edge.
    initial begin
        int        mcnt;
        int        k;
        int        mnb;
        bit        mact;
        logic [7:0] mb;
        logic [7:0] fr [13];
        bit [95:0] got;
        bit [95:0] want;
        mact = 0;
        mnb  = 0;
        mcnt = 0;
        mb   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mact = 0;
                mnb  = 0;
            end else if (!mact) begin
                if (uart_tx == 1'b0) begin
                    mact = 1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt % CPB == CPB / 2) begin
                    k = mcnt / CPB;
                    if (k == 0) begin
                        cmp("start_bit", uart_tx, 0);
                    end else if (k <= 8) begin
                        mb[k-1] = uart_tx;
                    end else begin
                        cmp("stop_bit", uart_tx, 1);
                        mact = 0;
                        fr[mnb] = mb;
                        mnb++;
                        if (mnb == 13) begin
                            mnb = 0;
                            cmp("sync", fr[0], 8'hA5);
                            got = {fr[1], fr[2], fr[3], fr[4], fr[5], fr[6],
                                   fr[7], fr[8], fr[9], fr[10], fr[11], fr[12]};
                            total++;
                            if (exp_q.size() == 0) begin
                                bad++;
                                $display("FAIL unexpected_frame got=%h want=none", got);
                            end else begin
                                want = exp_q.pop_front();
                                if (got != want) begin
                                    bad++;
                                    $display("FAIL frame got=%h want=%h", got, want);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int target;
        for (int i = 0; i < 3; i++) step(1, 1, cur);
        cmp("rst_tx", uart_tx, 1);
        cmp("rst_busy", busy, 0);
        cmp("rst_level", fifo_level, 0);
        cmp("rst_drop", drop_count, 0);

        hold(FRAME_CYC + 2000);
        cmp("hold_level", fifo_level, 0);
        cmp("hold_busy", busy, 0);

        cur[63:32] = 32'h12345678;
        hold(1);
        hold(1);
        cmp("chg_level", fifo_level, 1);
        hold(1);
        cmp("chg_load_tx", uart_tx, 1);
        hold(1);
        cmp("chg_start_tx", uart_tx, 0);
        drain();

        for (int i = 0; i < 20; i++) begin
            cur = {32'(100 + i), $urandom, 32'(i)};
            hold(1);
        end
        hold(1);
        cmp("drop20", drop_count, 3);
        drain();

        for (int i = 0; i < 2000; i++) begin
            cur_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) begin
                cur = {32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)),
                       32'hC0};
            end
            hold(1);
        end
        cur_en = 1'b1;
        drain();
        cmp("sb_empty", exp_q.size(), 0);

        for (int i = 0; i < 4; i++) begin
            cur = {32'hA000_0000 + 32'(i), $urandom, $urandom};
            hold(1);
        end
        target = last_pop + 2 + 55 * CPB;
        while (t < target) hold(1);
        step(1, 1, cur);
        step(0, 1, cur);
        cmp("abort_tx", uart_tx, 1);
        cmp("abort_level", fifo_level, 0);
        cmp("abort_drop", drop_count, 0);
        drain();
        cmp("sb_empty2", exp_q.size(), 0);

        for (int i = 0; i < 65800; i++) begin
            cur = {32'(t), ~32'(t), 32'(t) * 32'd3};
            hold(1);
        end
        hold(1);
        cmp("drop_sat", drop_count, 16'hFFFF);
        step(1, 0, cur);
        cur_en = 1'b0;
        hold(4);
        cmp("end_drop", drop_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
